// File: rtl/dsa_simd_fetch_unit.sv
// SIMD fetch unit: maps output lanes to source coordinates and
// fetches the four bilinear neighbours of every lane.
module dsa_simd_fetch_unit #(
  parameter int SIMD_WIDTH = 4,
  parameter int ADDR_W     = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic [15:0]             current_x,
  input  logic [15:0]             current_y,
  input  logic [15:0]             img_width_in,
  input  logic [15:0]             img_height_in,
  input  logic [15:0]             img_width_out,
  input  logic [15:0]             scale_x,
  input  logic [15:0]             scale_y,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [7:0]              mem_rd_data,
  output logic [SIMD_WIDTH*32-1:0] pix_out,
  output logic [SIMD_WIDTH*8-1:0] frac_x,
  output logic [7:0]              frac_y,
  output logic [SIMD_WIDTH-1:0]   lane_valid,
  output logic                    fetch_done,
  output logic                    busy
);

  localparam int NRD = 4 * SIMD_WIDTH;
  localparam int IW  = $clog2(NRD);
  localparam int LW  = IW - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;

  logic [IW-1:0] idx;
  logic [IW-1:0] cap_idx;
  logic          cap_en;

  logic [15:0] x0_q [SIMD_WIDTH];
  logic [15:0] x1_q [SIMD_WIDTH];
  logic [15:0] y0_q;
  logic [15:0] y1_q;

  logic [15:0]           cx0 [SIMD_WIDTH];
  logic [15:0]           cx1 [SIMD_WIDTH];
  logic [7:0]            cfx [SIMD_WIDTH];
  logic [SIMD_WIDTH-1:0] clv;
  logic [15:0]           cy0;
  logic [15:0]           cy1;
  logic [7:0]            cfy;

  logic [LW-1:0] lane;
  logic [1:0]    nb;
  logic [15:0]   ax;
  logic [15:0]   ay;

  // Scaled coordinate: {c0, c1, frac}, clamped to the last pixel.
  function automatic logic [39:0] map_coord(
    input logic [31:0] c,
    input logic [15:0] s,
    input logic [15:0] lim
  );
    logic [31:0] p;
    logic [15:0] c0;
    logic [15:0] c1;
    p  = c * {16'd0, s};
    c0 = p[23:8];
    if (p[31:24] != 8'd0 || c0 >= lim)
      c0 = lim - 16'd1;
    c1 = (c0 < lim - 16'd1) ? c0 + 16'd1 : lim - 16'd1;
    return {c0, c1, p[7:0]};
  endfunction

  // Per-lane source coordinates and lane mask for the CALC cycle.
  always_comb begin
    clv = '0;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      {cx0[i], cx1[i], cfx[i]} = map_coord(
        {16'd0, current_x} + 32'(i), scale_x, img_width_in);
      clv[i] = ({16'd0, current_x} + 32'(i)) <
               {16'd0, img_width_out};
    end
    {cy0, cy1, cfy} = map_coord(
      {16'd0, current_y}, scale_y, img_height_in);
  end

  // Neighbour select: idx is lane-major, low two bits pick p00..p11.
  always_comb begin
    lane = idx[IW-1:2];
    nb   = idx[1:0];
    ax   = nb[0] ? x1_q[lane] : x0_q[lane];
    ay   = nb[1] ? y1_q : y0_q;
  end

  assign mem_rd_en  = (state == S_ISSUE);
  assign fetch_done = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign mem_addr   = mem_rd_en
    ? ADDR_W'(ay) * ADDR_W'(img_width_in) + ADDR_W'(ax)
    : '0;

  // Sequencer, coordinate registers and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      cap_idx    <= '0;
      cap_en     <= 1'b0;
      pix_out    <= '0;
      frac_x     <= '0;
      frac_y     <= '0;
      lane_valid <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        x0_q[i] <= '0;
        x1_q[i] <= '0;
      end
    end else begin
      cap_en  <= (state == S_ISSUE);
      cap_idx <= idx;
      if (cap_en)
        pix_out[{cap_idx, 3'b000} +: 8] <= mem_rd_data;
      unique case (state)
        S_IDLE: begin
          if (fetch_req)
            state <= S_CALC;
        end
        S_CALC: begin
          for (int i = 0; i < SIMD_WIDTH; i++) begin
            x0_q[i]        <= cx0[i];
            x1_q[i]        <= cx1[i];
            frac_x[8*i +: 8] <= cfx[i];
          end
          y0_q       <= cy0;
          y1_q       <= cy1;
          frac_y     <= cfy;
          lane_valid <= clv;
          idx        <= '0;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (idx == IW'(NRD - 1)) begin
            idx   <= '0;
            state <= S_WAIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_WAIT: state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsa_simd_fetch_unit.sv
// Bench for dsa_simd_fetch_unit: reference model feeds a scoreboard,
// monitor compares addresses and results as the DUT presents them.
module tb_dsa_simd_fetch_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_req;
  logic [15:0]  current_x, current_y;
  logic [15:0]  img_width_in, img_height_in, img_width_out;
  logic [15:0]  scale_x, scale_y;
  logic         mem_rd_en;
  logic [17:0]  mem_addr;
  logic [7:0]   mem_rd_data = 8'd0;
  logic [127:0] pix_out;
  logic [31:0]  frac_x;
  logic [7:0]   frac_y;
  logic [3:0]   lane_valid;
  logic         fetch_done;
  logic         busy;

  typedef struct {
    logic [127:0] pix;
    logic [31:0]  fx;
    logic [7:0]   fy;
    logic [3:0]   lv;
    int           dc;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] addr_q[$];
  exp_t        me;
  logic [17:0] ma;
  logic [127:0] last_pix;
  logic [7:0]  key = 8'd0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rd_cnt = 0;

  dsa_simd_fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req),
    .current_x(current_x), .current_y(current_y),
    .img_width_in(img_width_in), .img_height_in(img_height_in),
    .img_width_out(img_width_out),
    .scale_x(scale_x), .scale_y(scale_y),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .pix_out(pix_out),
    .frac_x(frac_x), .frac_y(frac_y), .lane_valid(lane_valid),
    .fetch_done(fetch_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous source memory: content is address low byte xor key.
  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= mem_addr[7:0] ^ key;

  function automatic logic [7:0] mv(input int a);
    return a[7:0] ^ key;
  endfunction

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask

  // Source coordinate = floor(c*s/256), clamped to lim-1.
  task automatic map(input int c, input int s, input int lim,
                     output int c0, output int c1, output int f);
    longint p;
    p  = longint'(c) * longint'(s);
    c0 = int'(p / 256);
    f  = int'(p % 256);
    if (c0 > lim - 1) c0 = lim - 1;
    c1 = (c0 + 1 > lim - 1) ? lim - 1 : c0 + 1;
  endtask

  task automatic issue(input int x, input int y, input int wi,
                       input int hi, input int wo, input int sx,
                       input int sy, output int rc);
    exp_t e;
    int x0, x1, y0, y1, f, fy, a;
    int xs[4];
    int ys[4];
    map(y, sy, hi, y0, y1, fy);
    e.pix = '0;
    e.fx  = '0;
    e.lv  = '0;
    e.fy  = fy[7:0];
    for (int l = 0; l < 4; l++) begin
      map(x + l, sx, wi, x0, x1, f);
      e.fx[8*l +: 8] = f[7:0];
      e.lv[l] = (x + l < wo);
      xs = '{x0, x1, x0, x1};
      ys = '{y0, y0, y1, y1};
      for (int n = 0; n < 4; n++) begin
        a = (ys[n] * wi + xs[n]) & 32'h3FFFF;
        addr_q.push_back(a[17:0]);
        e.pix[32*l + 8*n +: 8] = mv(a);
      end
    end
    last_pix = e.pix;
    @(negedge clk);
    current_x     = x[15:0];
    current_y     = y[15:0];
    img_width_in  = wi[15:0];
    img_height_in = hi[15:0];
    img_width_out = wo[15:0];
    scale_x       = sx[15:0];
    scale_y       = sy[15:0];
    fetch_req     = 1'b1;
    rc   = cyc;
    e.dc = cyc + 19;
    exp_q.push_back(e);
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("done_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops expected addresses and results as the DUT shows them.
  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_cnt++;
      if (addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_read: addr %0h with nothing expected",
                 mem_addr);
      end else begin
        ma = addr_q.pop_front();
        chk("mem_addr", mem_addr, ma);
      end
    end
    if (fetch_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_done: fetch_done at cycle %0d", cyc);
      end else begin
        me = exp_q.pop_front();
        chk("pix_out", pix_out, me.pix);
        chk("frac_x", frac_x, me.fx);
        chk("frac_y", frac_y, me.fy);
        chk("lane_valid", lane_valid, me.lv);
        chk("done_cycle", cyc, me.dc);
        chk("busy_done", busy, 1);
      end
    end
  end

  initial begin
    int rc, r0, x, y, wi, hi, wo, sx, sy;
    rst = 1'b1;
    fetch_req = 1'b0;
    current_x = '0; current_y = '0;
    img_width_in = 16'd4; img_height_in = 16'd4;
    img_width_out = 16'd8;
    scale_x = '0; scale_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", fetch_done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_fx", frac_x, 0);
    chk("rst_fy", frac_y, 0);
    chk("rst_lv", lane_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    r0 = rd_cnt;
    issue(0, 0, 4, 4, 8, 'h80, 'h80, rc);
    wait_done();
    chk("basic_pix", pix_out,
        128'h06050201_06050201_05040100_05040100);
    chk("basic_fx", frac_x, 32'h80008000);
    chk("basic_fy", frac_y, 8'h00);
    chk("basic_lv", lane_valid, 4'b1111);
    chk("basic_reads", rd_cnt - r0, 16);

    issue(4, 7, 4, 4, 8, 'h80, 'h80, rc);
    wait_done();
    chk("clamp_pix_hi", pix_out[127:64], 64'h0F0F0F0F_0F0F0F0F);
    chk("clamp_fx3", frac_x[31:24], 8'h80);
    chk("clamp_fy", frac_y, 8'h80);

    issue(4, 0, 4, 4, 6, 'h80, 'h80, rc);
    wait_done();
    chk("mask_lv", lane_valid, 4'b0011);

    issue(300, 0, 16, 4, 8, 'hFFFF, 'h80, rc);
    wait_done();
    chk("sat_pix", pix_out, {4{32'h1F1F0F0F}});

    key = 8'h5A;
    issue(8, 3, 20, 10, 30, 'hC0, 'hA0, rc);
    while (cyc < rc + 5) @(negedge clk);
    fetch_req = 1'b1;
    current_x = 16'd77;
    @(negedge clk);
    fetch_req = 1'b0;
    wait_done();
    repeat (25) @(negedge clk);
    chk("hold_pix", pix_out, last_pix);

    key = 8'h00;
    issue(0, 0, 4, 4, 8, 'h80, 'h80, rc);
    while (cyc < rc + 8) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    #1;
    chk("mid_rst_rd_en", mem_rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", fetch_done, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_pix", pix_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    issue(0, 0, 4, 4, 8, 'h80, 'h80, rc);
    wait_done();
    chk("post_rst_pix", pix_out,
        128'h06050201_06050201_05040100_05040100);

    for (int t = 0; t < 40; t++) begin
      key = 8'($urandom);
      wi = $urandom_range(1, 1023);
      hi = $urandom_range(1, 400);
      wo = $urandom_range(1, 1100);
      x  = $urandom_range(0, 1100);
      y  = $urandom_range(0, 450);
      sx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535)
                                       : $urandom_range(1, 512);
      sy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535)
                                       : $urandom_range(1, 512);
      issue(x, y, wi, hi, wo, sx, sy, rc);
      wait_done();
    end

    chk("addr_q_empty", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
